// File: rtl/regfile_write_scheduler.sv
// Write-port arbiter for the 32-entry register file: clears x1..x31 after reset,
// then grants one write per cycle, with requester 0 first and requester 1 protected by an aging counter.
module regfile_write_scheduler #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [4:0]      req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] di3,
    output logic            we3,
    output logic            init_done,
    output logic            grant1
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] di3_q, di3_d;
    logic            we3_q, we3_d;
    logic            init_done_q, init_done_d;
    logic            grant1_q, grant1_d;
    logic [3:0]      wait1_q, wait1_d;
    logic            gnt0, gnt1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (init_done_q) begin
            if (wait1_q == MAX_W && req1_valid) begin
                gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a3_d        = a3_q;
        di3_d       = di3_q;
        we3_d       = 1'b0;
        init_done_d = init_done_q;
        grant1_d    = grant1_q;
        wait1_d     = wait1_q;

        case (state_q)
            CLEAR: begin
                // Index runs to 32 so the edge after loading x31 is the one that finishes.
                if (idx_q == 6'd32) begin
                    init_done_d = 1'b1;
                    state_d     = RUN;
                end else begin
                    a3_d  = idx_q[4:0];
                    di3_d = '0;
                    we3_d = 1'b1;
                    idx_d = idx_q + 6'd1;
                end
            end
            RUN: begin
                if (gnt1) begin
                    a3_d     = req1_addr;
                    di3_d    = req1_data;
                    grant1_d = 1'b1;
                    we3_d    = (req1_addr != 5'd0);
                end else if (gnt0) begin
                    a3_d     = req0_addr;
                    di3_d    = req0_data;
                    grant1_d = 1'b0;
                    we3_d    = (req0_addr != 5'd0);
                end
            end
            default: state_d = CLEAR;
        endcase

        if (gnt1) begin
            wait1_d = '0;
        end else if (req1_valid && wait1_q < MAX_W) begin
            wait1_d = wait1_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            idx_q       <= 6'd1;
            a3_q        <= '0;
            di3_q       <= '0;
            we3_q       <= 1'b0;
            init_done_q <= 1'b0;
            grant1_q    <= 1'b0;
            wait1_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a3_q        <= a3_d;
            di3_q       <= di3_d;
            we3_q       <= we3_d;
            init_done_q <= init_done_d;
            grant1_q    <= grant1_d;
            wait1_q     <= wait1_d;
        end
    end

    assign a3        = a3_q;
    assign di3       = di3_q;
    assign we3       = we3_q;
    assign init_done = init_done_q;
    assign grant1    = grant1_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: clear sequence, vector table of grants/writes,
// idle hold, aging after idle, and asynchronous reset in the middle of a write.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  a3;
    logic [31:0] di3;
    logic        we3, init_done, grant1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rf [32];

    regfile_write_scheduler #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .a3         (a3),
        .di3        (di3),
        .we3        (we3),
        .init_done  (init_done),
        .grant1     (grant1)
    );

    always #5 clk = ~clk;

    // Register file behaviour: written on the edge while we3 is high.
    always @(posedge clk) begin
        if (we3) rf[a3] <= di3;
    end

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  ea3;
        logic [31:0] edi;
        logic        g1;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic r0, input logic r1, input logic we,
                                input logic [4:0] ea3, input logic [31:0] edi, input logic g1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = we;
        v.ea3 = ea3; v.edi = edi; v.g1 = g1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic junk_rf();
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = 32'hCAFE_0000 + 32'(i);
    endtask

    // Called at posedge+1 right after reset is released; req0_valid is held high throughout.
    task automatic run_clear();
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            chk("clr_we3", 64'(we3), 64'd1);
            chk("clr_a3", 64'(a3), 64'(k));
            chk("clr_di3", 64'(di3), 64'd0);
            chk("clr_init", 64'(init_done), 64'd0);
            chk("clr_rdy0", 64'(req0_ready), 64'd0);
        end
        @(posedge clk); #1;
        chk("clr_end_we3", 64'(we3), 64'd0);
        chk("clr_end_init", 64'(init_done), 64'd1);
        chk("clr_end_rdy0", 64'(req0_ready), 64'd1);
        chk("clr_end_g1", 64'(grant1), 64'd0);
        req0_valid = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) chk($sformatf("clr_rf%0d", i), 64'(rf[i]), 64'd0);
    endtask

    vec_t vecs [17];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1, 5'd1, 32'd69,   0, 5'd0, 32'd0,      1, 0, 1, 5'd1, 32'd69,       0);
        vecs[1]  = mk(0, 5'd0, 32'd0,    0, 5'd0, 32'd0,      0, 0, 0, 5'd1, 32'd69,       0);
        vecs[2]  = mk(0, 5'd0, 32'd0,    1, 5'd0, 32'hDEAD,   0, 1, 0, 5'd0, 32'hDEAD,     1);
        vecs[3]  = mk(0, 5'd0, 32'd0,    1, 5'd5, 32'h55,     0, 1, 1, 5'd5, 32'h55,       1);
        vecs[4]  = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[5]  = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[6]  = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[7]  = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[8]  = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     0, 1, 1, 5'd3, 32'hBB,       1);
        vecs[9]  = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[10] = mk(1, 5'd7, 32'h77,   0, 5'd0, 32'd0,      1, 0, 1, 5'd7, 32'h77,       0);
        vecs[11] = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[12] = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[13] = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     1, 0, 1, 5'd2, 32'hAA,       0);
        vecs[14] = mk(1, 5'd2, 32'hAA,   1, 5'd3, 32'hBB,     0, 1, 1, 5'd3, 32'hBB,       1);
        vecs[15] = mk(0, 5'd0, 32'd0,    0, 5'd0, 32'd0,      0, 0, 0, 5'd3, 32'hBB,       1);
        vecs[16] = mk(1, 5'd0, 32'h12,   0, 5'd0, 32'd0,      1, 0, 0, 5'd0, 32'h12,       0);

        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
        junk_rf();
        @(posedge clk); #1;
        chk("rst_a3", 64'(a3), 64'd0);
        chk("rst_di3", 64'(di3), 64'd0);
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_init", 64'(init_done), 64'd0);
        chk("rst_g1", 64'(grant1), 64'd0);
        chk("rst_rdy0", 64'(req0_ready), 64'd0);
        reset = 1'b0;
        run_clear();

        foreach (vecs[i]) begin
            req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
            #1;
            chk($sformatf("v%0d_rdy0", i), 64'(req0_ready), 64'(vecs[i].r0));
            chk($sformatf("v%0d_rdy1", i), 64'(req1_ready), 64'(vecs[i].r1));
            @(posedge clk); #1;
            chk($sformatf("v%0d_we3", i), 64'(we3), 64'(vecs[i].we));
            chk($sformatf("v%0d_a3", i), 64'(a3), 64'(vecs[i].ea3));
            chk($sformatf("v%0d_di3", i), 64'(di3), 64'(vecs[i].edi));
            chk($sformatf("v%0d_g1", i), 64'(grant1), 64'(vecs[i].g1));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        chk("rf_x0", 64'(rf[0]), 64'd0);
        chk("rf_x1", 64'(rf[1]), 64'd69);
        chk("rf_x2", 64'(rf[2]), 64'hAA);
        chk("rf_x3", 64'(rf[3]), 64'hBB);
        chk("rf_x5", 64'(rf[5]), 64'h55);
        chk("rf_x7", 64'(rf[7]), 64'h77);

        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("idle_we3", 64'(we3), 64'd0);
            chk("idle_a3", 64'(a3), 64'd0);
            chk("idle_di3", 64'(di3), 64'h12);
            chk("idle_rdy", 64'({req0_ready, req1_ready}), 64'd0);
        end

        // Aging must restart from zero after the idle stretch: four wins for 0, then one for 1.
        req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'hB0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("age_rdy0", 64'(req0_ready), 64'(c != 4));
            chk("age_rdy1", 64'(req1_ready), 64'(c == 4));
            @(posedge clk); #1;
            chk("age_g1", 64'(grant1), 64'(c == 4));
            chk("age_a3", 64'(a3), (c == 4) ? 64'd3 : 64'd2);
        end
        req1_valid = 1'b0;

        req0_addr = 5'd9; req0_data = 32'h99;
        @(posedge clk); #1;
        chk("mid_we3_pre", 64'(we3), 64'd1);
        chk("mid_a3_pre", 64'(a3), 64'd9);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_we3", 64'(we3), 64'd0);
        chk("mid_init", 64'(init_done), 64'd0);
        chk("mid_rdy0", 64'(req0_ready), 64'd0);
        chk("mid_a3", 64'(a3), 64'd0);
        junk_rf();
        @(posedge clk); #1;
        chk("mid_hold_we3", 64'(we3), 64'd0);
        reset = 1'b0;
        run_clear();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Arbitrates the single write port of the 32-entry register file between two write-back requesters: requester 0 is the ALU/execute path and requester 1 is the multi-cycle load/mul path. After reset it runs a clear sequence that writes zero to x1..x31. During normal operation it grants at most one write per cycle. Requester 0 has fixed priority, and an aging counter guarantees requester 1 is not starved. Outputs drive the register file write port (`a3`, `di3`, `we3`) directly from flops.

## Interface
- `XLEN`, default 32: data width; matches the register file data width.
- `MAX_WAIT`, default 4, legal range 1..15: number of consecutive stalled cycles after which requester 1 overrides requester 0.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 holds a write request.
- `req0_addr`  in  5  requester 0 destination register.
- `req0_data`  in  XLEN  requester 0 write data.
- `req0_ready`  out  1  requester 0 request accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: requester 1, same widths and meanings as requester 0.
- `a3`  out  5  register file write address.
- `di3`  out  XLEN  register file write data.
- `we3`  out  1  register file write enable.
- `init_done`  out  1  clear sequence finished; requests may be accepted.
- `grant1`  out  1  registered; 1 when the write currently on `a3`/`di3` came from requester 1.

## Operation
- **States**
  - CLEAR: entered on reset; walks index 1..31.
  - RUN: steady state after CLEAR; never left except through reset.
- **Reset values:** `a3`=0, `di3`=0, `we3`=0, `init_done`=0, `grant1`=0, wait counter=0, clear index=1, state=CLEAR. `req0_ready` and `req1_ready` are 0 while `init_done`=0.
- **CLEAR state**
  - Each edge registers `a3`=index, `di3`=0, `we3`=1, then increments index.
  - After the edge that loads index 31, the next edge loads `we3`=0 and `init_done`=1, and the state becomes RUN.
  - x0 is never written.
- **RUN grant, combinational from current valids and the wait counter**
  - If `wait1`==`MAX_WAIT` and `req1_valid`: grant requester 1.
  - Else if `req0_valid`: grant requester 0.
  - Else if `req1_valid`: grant requester 1.
  - Else: no grant.
  - `reqN_ready` = 1 exactly for the granted requester. A handshake completes when valid && ready.
- **Accepted request:** the next edge registers `a3`=addr, `di3`=data, `grant1`=(requester==1), and `we3`=(addr!=0). A write to x0 completes the handshake but never asserts `we3`.
- **No grant:** the next edge registers `we3`=0. `a3`, `di3` and `grant1` hold their values.
- **Wait counter `wait1` (4 bits)**
  - Cleared on any requester-1 accept.
  - Otherwise increments when `req1_valid` && !`req1_ready`, saturating at `MAX_WAIT`.
  - Unchanged when `req1_valid`=0.
- **Ordering:** no address comparison is done between requesters. If both target the same register, the later-accepted write wins. Ordering is the requesters' responsibility.
- **Reset mid-operation:** asynchronously forces all reset values. Any registered write is dropped (`we3` falls immediately) and CLEAR restarts from index 1.

## Timing
- **Clear length:** 31 write cycles. `init_done` rises on the 32nd rising edge after `reset` deasserts; readies may assert in that same cycle.
- **Write latency:** a request accepted at edge N appears on `a3`/`di3`/`we3` during cycle N+1 and is written into the register file at edge N+1. A read of that register returns the new value from cycle N+2.
- **Throughput:** one write per cycle, summed over both requesters.
- **Readies** are combinational from the valids, `wait1` and `init_done`; there is no path from readies back to valids.
- **Worst-case requester-1 latency** under continuous requester-0 traffic is `MAX_WAIT`+1 cycles from assertion to accept.

## Test plan
- **Reset/clear:** pulse `reset`, then release -> `we3`=1 for 31 consecutive cycles with `a3`=1..31 and `di3`=0; `init_done`=1 after edge 32; all registers read 0; readies stay 0 until then.
- **Single write:** `req0_valid`=1, addr=1, data=69 -> `req0_ready`=1 in the same cycle; next cycle `a3`=1, `di3`=69, `we3`=1; reading register 1 afterwards returns 69.
- **Contention, `MAX_WAIT`=4:** both valid continuously, addr 2/3, data 0xAA/0xBB -> `req0_ready` is high for 4 cycles, then `req1_ready` for 1 cycle (`grant1`=1 on the following cycle), then `wait1`=0 and requester 0 wins again.
- **x0 write:** `req1_valid`, addr=0, data=0xDEAD -> `req1_ready`=1, `we3` stays 0, register 0 reads 0.
- **Reset mid-write:** assert `reset` in a cycle where `we3`=1 -> `we3`, `init_done` and both readies drop to 0 without waiting for a clock edge; after release, the full 31-write clear repeats.
- **Idle:** no valids for 10 cycles after `init_done` -> `we3`=0 throughout, `wait1` holds at 0, `a3`/`di3` unchanged.
